branch_predict_sequencer: RTL and testbench
===========================================

Name: branch_predict_sequencer

Overview:
Sits between the fetch stage, the 2-bit-counter branch predictor and the branch resolution unit. Sequences predictor lookups (request/registered-response timing) and queues each in-flight prediction in order. Retires resolutions against the queue head, forwards training updates (result/taken) to the predictor, and detects mispredictions. On a misprediction it flushes the younger in-flight entries, stalls fetch for a recovery window and keeps saturating statistics.

Parameters:
DEPTH, 4, max in-flight unresolved branches (power of 2, >=2)
RECOVER_CYC, 2, fetch-stall cycles after a mispredict (>=1)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
fetch_req  in  1  fetch requests a prediction for a branch
fetch_ready  out  1  sequencer can accept fetch_req this cycle
pred_valid  out  1  one-cycle pulse: pred_taken is valid
pred_taken  out  1  predicted direction returned to fetch
bp_request  out  1  drives predictor request
bp_prediction  in  1  predictor prediction output (registered; valid the cycle after bp_request)
bp_result  out  1  drives predictor result (training strobe)
bp_taken  out  1  drives predictor taken (actual outcome)
resolve_valid  in  1  resolution unit reports the oldest branch outcome
resolve_taken  in  1  actual direction of that branch
mispredict  out  1  one-cycle pulse, registered
flush  out  1  high during RECOVER
resolve_err  out  1  one-cycle pulse, registered: resolve_valid with empty queue
inflight  out  $clog2(DEPTH)+1  current queue occupancy
branch_count  out  CNT_W  resolved branches, saturating
mispredict_count  out  CNT_W  mispredictions, saturating

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE, queue empty, inflight=0.
  - pred_valid, pred_taken, mispredict, flush, resolve_err = 0; both counters = 0.
  - Reset mid-operation discards all in-flight entries immediately.
- FSM states: IDLE, WAIT_PRED, RECOVER.
- fetch_ready = (state==IDLE) && (inflight<DEPTH), combinational.
- IDLE:
  - fetch_req && fetch_ready: bp_request=1 combinationally this cycle; next state WAIT_PRED.
  - fetch_req while !fetch_ready is ignored; no retention.
- WAIT_PRED, exactly one cycle:
  - Sample bp_prediction and push it at the queue tail.
  - pred_valid=1 and pred_taken=bp_prediction, both registered and visible the following cycle.
  - Next state IDLE.
  - Request-to-pred_valid latency is 2 cycles; maximum throughput is one prediction per 2 cycles.
- Resolution, accepted in any state except during reset:
  - resolve_valid && inflight>0: pop the head; bp_result=1 and bp_taken=resolve_taken combinationally the same cycle; branch_count +1 (saturating at all-ones).
  - A predictor lookup and a training update in the same cycle are legal; the predictor returns the pre-update counter.
  - resolve_valid && inflight==0: no pop, bp_result=0, resolve_err pulses next cycle, counters unchanged.
- Mispredict (popped head != resolve_taken):
  - Next cycle: mispredict pulses; mispredict_count +1 (saturating).
  - All remaining queue entries are discarded (inflight=0).
  - State enters RECOVER for RECOVER_CYC cycles; flush=1 throughout; fetch_ready=0.
  - Then state returns to IDLE.
  - Mispredict during WAIT_PRED: the pending prediction is discarded (no push, no pred_valid).
  - Resolutions during RECOVER see an empty queue and raise resolve_err.
- Push and pop in the same cycle with no mispredict: inflight unchanged; queue order preserved.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy is tracked separately so full and empty are distinguishable.
- bp_request, bp_result and bp_taken are 0 whenever not asserted as above.

Test Plan:
- Reset, then fetch_req at cycle 0 with bp_prediction=0 at cycle 1 -> bp_request=1 in cycle 0; pred_valid=1, pred_taken=0 at cycle 2; inflight=1.
- Four accepted predictions (DEPTH=4) with no resolves -> inflight=4; fetch_ready=0; a fifth fetch_req produces no bp_request. One correct resolve -> inflight=3, fetch_ready=1.
- Queue [1,0,1], resolve_taken 1 then 0 -> bp_result pulses twice with bp_taken 1,0; branch_count=2; mispredict never asserts.
- Queue [0,1,1], resolve_taken=1 -> bp_taken=1; next cycle mispredict=1, inflight=0, flush=1 for 2 cycles with fetch_ready=0; mispredict_count=1.
- resolve_valid with an empty queue -> resolve_err pulses once; bp_result=0; counters unchanged.
- Push and pop in the same cycle at inflight=2 -> inflight stays 2, FIFO order verified over 2*DEPTH pointer wraps. rst_n dropped mid-WAIT_PRED -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/branch_predict_sequencer.sv
// Sequences 2-bit predictor lookups, tracks in-flight predictions in order,
// retires resolutions against the oldest entry and recovers on mispredicts.
module branch_predict_sequencer #(
    parameter int DEPTH       = 4,
    parameter int RECOVER_CYC = 2,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_req,
    output logic                     fetch_ready,
    output logic                     pred_valid,
    output logic                     pred_taken,
    output logic                     bp_request,
    input  logic                     bp_prediction,
    output logic                     bp_result,
    output logic                     bp_taken,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    output logic                     mispredict,
    output logic                     flush,
    output logic                     resolve_err,
    output logic [$clog2(DEPTH):0]   inflight,
    output logic [CNT_W-1:0]         branch_count,
    output logic [CNT_W-1:0]         mispredict_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int RW = $clog2(RECOVER_CYC + 1);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_PRED, RECOVER} state_t;

    state_t           state;
    logic [DEPTH-1:0] q;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [RW-1:0]    rec_cnt;
    logic             pop, push, miss;

    assign fetch_ready = (state == IDLE) && (inflight < FULL);
    assign bp_request  = fetch_req && fetch_ready;
    assign pop         = resolve_valid && (inflight != '0);
    assign bp_result   = pop;
    assign bp_taken    = pop && resolve_taken;
    assign miss        = pop && (q[rd_ptr] != resolve_taken);
    // A mispredict in the lookup cycle kills the younger pending prediction
    assign push        = (state == WAIT_PRED) && !miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            q                <= '0;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            rec_cnt          <= '0;
            inflight         <= '0;
            pred_valid       <= 1'b0;
            pred_taken       <= 1'b0;
            mispredict       <= 1'b0;
            flush            <= 1'b0;
            resolve_err      <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            pred_valid  <= push;
            pred_taken  <= push && bp_prediction;
            mispredict  <= miss;
            resolve_err <= resolve_valid && (inflight == '0);

            if (push) begin
                q[wr_ptr] <= bp_prediction;
                wr_ptr    <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                if (branch_count != '1) branch_count <= branch_count + CNT_W'(1);
            end

            if (miss) begin
                if (mispredict_count != '1) mispredict_count <= mispredict_count + CNT_W'(1);
                // Collapse the queue onto the write pointer: everything younger is gone
                rd_ptr   <= wr_ptr;
                inflight <= '0;
                state    <= RECOVER;
                rec_cnt  <= RW'(RECOVER_CYC - 1);
                flush    <= 1'b1;
            end else begin
                inflight <= inflight + (PW+1)'(push) - (PW+1)'(pop);
                case (state)
                    IDLE:      if (bp_request) state <= WAIT_PRED;
                    WAIT_PRED: state <= IDLE;
                    RECOVER: begin
                        if (rec_cnt == '0) begin
                            state <= IDLE;
                            flush <= 1'b0;
                        end else begin
                            rec_cnt <= rec_cnt - RW'(1);
                        end
                    end
                    default:   state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_branch_predict_sequencer.sv
// Directed and random checks of the branch sequencer against a queue-based model.
module tb_branch_predict_sequencer;
    localparam int DEPTH = 4;
    localparam int RCYC  = 2;
    localparam int CW    = 5;
    localparam int MAXC  = (1 << CW) - 1;

    logic clk = 1'b0, rst_n = 1'b0;
    logic fetch_req = 1'b0, bp_prediction = 1'b0, resolve_valid = 1'b0, resolve_taken = 1'b0;
    logic fetch_ready, pred_valid, pred_taken, bp_request, bp_result, bp_taken;
    logic mispredict, flush, resolve_err;
    logic [$clog2(DEPTH):0] inflight;
    logic [CW-1:0] branch_count, mispredict_count;

    int checks = 0, failures = 0;

    // Model: queue of predicted directions plus "lookup pending" and "stall cycles left"
    bit mq[$];
    bit pend;
    int rec, bc, mc;
    bit e_pv, e_pt, e_mis, e_err;

    branch_predict_sequencer #(.DEPTH(DEPTH), .RECOVER_CYC(RCYC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_ready(fetch_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .bp_request(bp_request),
        .bp_prediction(bp_prediction), .bp_result(bp_result), .bp_taken(bp_taken),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .mispredict(mispredict), .flush(flush), .resolve_err(resolve_err),
        .inflight(inflight), .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pend = 0; rec = 0; bc = 0; mc = 0;
        e_pv = 0; e_pt = 0; e_mis = 0; e_err = 0;
    endtask

    task automatic step(input bit fr, input bit bpp, input bit rv, input bit rt);
        bit rdy, req, res, mis, head;
        int n;
        @(negedge clk);
        fetch_req = fr; bp_prediction = bpp; resolve_valid = rv; resolve_taken = rt;
        #1;
        n   = mq.size();
        rdy = !pend && (rec == 0) && (n < DEPTH);
        req = fr && rdy;
        res = rv && (n > 0);
        chk("fetch_ready", 32'(fetch_ready), 32'(rdy));
        chk("bp_request", 32'(bp_request), 32'(req));
        chk("bp_result", 32'(bp_result), 32'(res));
        chk("bp_taken", 32'(bp_taken), 32'(res && rt));
        chk("pred_valid", 32'(pred_valid), 32'(e_pv));
        if (e_pv) chk("pred_taken", 32'(pred_taken), 32'(e_pt));
        chk("mispredict", 32'(mispredict), 32'(e_mis));
        chk("flush", 32'(flush), 32'(rec > 0));
        chk("resolve_err", 32'(resolve_err), 32'(e_err));
        chk("inflight", 32'(inflight), 32'(n));
        chk("branch_count", 32'(branch_count), 32'(bc));
        chk("mispredict_count", 32'(mispredict_count), 32'(mc));

        head  = (n > 0) ? mq[0] : 1'b0;
        mis   = res && (head != rt);
        e_err = rv && (n == 0);
        e_mis = mis;
        e_pv  = 0;
        if (res) begin
            void'(mq.pop_front());
            if (bc < MAXC) bc++;
        end
        if (mis) begin
            mq.delete();
            if (mc < MAXC) mc++;
            rec  = RCYC;
            pend = 0;
        end else if (pend) begin
            mq.push_back(bpp);
            e_pv = 1; e_pt = bpp; pend = 0;
        end else if (rec > 0) begin
            rec--;
        end else if (req) begin
            pend = 1;
        end
    endtask

    task automatic fetch(input bit p);
        step(1, 0, 0, 0);
        step(0, p, 0, 0);
    endtask

    task automatic drain();
        while (mq.size() > 0) step(0, 0, 1, mq[0]);
        step(0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Reset state and first lookup: pred_taken=0 two cycles after request
        step(0, 0, 0, 0);
        fetch(0);
        step(0, 0, 0, 0);

        // Fill to DEPTH, fifth request ignored, one correct resolve frees a slot
        fetch(1); fetch(0); fetch(1);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("full_no_request", 32'(bp_request), 32'd0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("inflight_after_pop", 32'(inflight), 32'd3);
        drain();

        // Queue [1,0,1]: two correct resolves, no mispredict
        fetch(1); fetch(0); fetch(1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        drain();

        // Queue [0,1,1]: taken resolve against a not-taken head -> recovery
        fetch(0); fetch(1); fetch(1);
        step(0, 0, 1, 1);
        repeat (RCYC + 2) step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        drain();

        // Resolve against an empty queue
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Mispredict in the lookup cycle drops the pending prediction
        fetch(1);
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        repeat (RCYC + 1) step(0, 0, 0, 0);

        // Steady push+pop at occupancy 2, many pointer wraps
        fetch($urandom_range(1)); fetch($urandom_range(1));
        for (int i = 0; i < 2 * DEPTH * DEPTH; i++) begin
            step(1, 0, 0, 0);
            step(0, 1'($urandom_range(1)), 1, mq[0]);
        end
        step(0, 0, 0, 0);

        // Async reset while a lookup is pending
        step(1, 0, 0, 0);
        @(posedge clk); #2;
        fetch_req = 0; resolve_valid = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_pred_valid", 32'(pred_valid), 32'd0);
        chk("rst_pred_taken", 32'(pred_taken), 32'd0);
        chk("rst_mispredict", 32'(mispredict), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_resolve_err", 32'(resolve_err), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_branch_count", 32'(branch_count), 32'd0);
        chk("rst_mispredict_count", 32'(mispredict_count), 32'd0);
        chk("rst_bp_request", 32'(bp_request), 32'd0);
        chk("rst_bp_result", 32'(bp_result), 32'd0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        // Random traffic, mostly correct resolves; long enough to saturate counters
        for (int i = 0; i < 3000; i++) begin
            bit rv, rt;
            rv = ($urandom_range(2) == 0);
            rt = (mq.size() > 0 && $urandom_range(3) != 0) ? mq[0] : 1'($urandom_range(1));
            step(1'($urandom_range(1)), 1'($urandom_range(1)), rv, rt);
        end
        step(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
